// File: rtl/btt_pkg.sv
// Shared definitions for the branch target table.
// Contents: clear-sequencer state enum, default parameter constants,
// and target/index helper typedefs sized to those defaults.
package btt_pkg;

  localparam int DEF_IDX_W    = 4;
  localparam int DEF_TGT_W    = 12;
  localparam int DEF_NUM_BASE = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef logic [DEF_TGT_W-1:0] tgt_t;
  typedef logic [DEF_IDX_W-1:0] idx_t;

endpackage

// File: rtl/branch_target_table_if.sv
// Bus bundle for the branch target table.
// master: drives clear request, entry/base writes and lookups;
//         receives busy and the registered lookup response.
// slave : the table itself (opposite directions).
interface branch_target_table_if #(
  parameter int IDX_W  = 4,
  parameter int TGT_W  = 12,
  parameter int BSEL_W = 2
);
  logic              clr_req;
  logic              busy;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [TGT_W-1:0]  wr_tgt;
  logic              base_wr_en;
  logic [BSEL_W-1:0] base_wr_sel;
  logic [TGT_W-1:0]  base_wr_val;
  logic              rd_req;
  logic [IDX_W-1:0]  rd_idx;
  logic [BSEL_W-1:0] rd_base_sel;
  logic              rd_valid;
  logic              rd_hit;
  logic [TGT_W-1:0]  target;

  modport master (
    output clr_req, wr_en, wr_idx, wr_tgt,
    output base_wr_en, base_wr_sel, base_wr_val,
    output rd_req, rd_idx, rd_base_sel,
    input  busy, rd_valid, rd_hit, target
  );

  modport slave (
    input  clr_req, wr_en, wr_idx, wr_tgt,
    input  base_wr_en, base_wr_sel, base_wr_val,
    input  rd_req, rd_idx, rd_base_sel,
    output busy, rd_valid, rd_hit, target
  );
endinterface

// File: rtl/btt_clear_seq.sv
// Clear sweep sequencer for the branch target table.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr_req   - start a sweep (only honoured while idle)
//   busy      - registered, high for exactly 2**IDX_W cycles per sweep
//   clr_we    - invalidate strobe for entry clr_idx this cycle
//   clr_idx   - entry currently being invalidated
module btt_clear_seq
  import btt_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  state_t           state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic             busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clr_req) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          // The last entry is cleared on the same cycle we head back to IDLE.
          if (ptr_reg == LAST_IDX) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            ptr_reg <= ptr_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ptr_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign clr_we  = (state_reg == CLEAR);
  assign clr_idx = ptr_reg;

endmodule

// File: rtl/branch_target_table.sv
// Programmable branch target table for the fetch stage.
// Maps a short branch index to an absolute PC target: entry value plus a
// selectable per-segment base register, wrapping at 2**TGT_W.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - slave side of branch_target_table_if:
//              clr_req/busy, entry write, base write, lookup request and
//              the registered response (rd_valid, rd_hit, target).
module branch_target_table
  import btt_pkg::*;
#(
  parameter int IDX_W    = DEF_IDX_W,
  parameter int TGT_W    = DEF_TGT_W,
  parameter int NUM_BASE = DEF_NUM_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_target_table_if.slave  bus
);

  localparam int DEPTH  = 2 ** IDX_W;
  localparam int BSEL_W = $clog2(NUM_BASE);

  logic             busy;
  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;

  btt_clear_seq #(
    .IDX_W (IDX_W)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .clr_req (bus.clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // Entry writes are only accepted outside a sweep.
  logic wr_ok;
  assign wr_ok = bus.wr_en & ~busy;

  // Entry payload: no reset, validity is tracked separately.
  logic [TGT_W-1:0] data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      data_mem[bus.wr_idx] <= bus.wr_tgt;
    end
  end

  logic [DEPTH-1:0]  valid_vec;
  logic [TGT_W-1:0]  base_vec [NUM_BASE];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic v_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_reg <= 1'b0;
        end else if (clr_we && (clr_idx == IDX_W'(gi))) begin
          v_reg <= 1'b0;
        end else if (wr_ok && (bus.wr_idx == IDX_W'(gi))) begin
          v_reg <= 1'b1;
        end
      end
      assign valid_vec[gi] = v_reg;
    end

    for (genvar gi = 0; gi < NUM_BASE; gi++) begin : g_base
      logic [TGT_W-1:0] b_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          b_reg <= '0;
        end else if (bus.base_wr_en && (bus.base_wr_sel == BSEL_W'(gi))) begin
          b_reg <= bus.base_wr_val;
        end
      end
      assign base_vec[gi] = b_reg;
    end
  endgenerate

  // Lookup with same-cycle forwarding of entry and base writes.
  logic             ent_fwd;
  logic             ent_valid;
  logic [TGT_W-1:0] ent_data;
  logic [TGT_W-1:0] base_val;
  logic             hit_next;
  logic [TGT_W-1:0] tgt_next;

  always_comb begin
    ent_fwd   = wr_ok && (bus.wr_idx == bus.rd_idx);
    ent_valid = valid_vec[bus.rd_idx] | ent_fwd;
    ent_data  = ent_fwd ? bus.wr_tgt : data_mem[bus.rd_idx];
    if (bus.base_wr_en && (bus.base_wr_sel == bus.rd_base_sel)) begin
      base_val = bus.base_wr_val;
    end else begin
      base_val = base_vec[bus.rd_base_sel];
    end
    // Everything reads as a miss while sweeping; the add wraps naturally.
    hit_next = bus.rd_req & ~busy & ent_valid;
    tgt_next = hit_next ? (ent_data + base_val) : '0;
  end

  logic             rd_valid_reg;
  logic             rd_hit_reg;
  logic [TGT_W-1:0] target_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rd_hit_reg   <= 1'b0;
      target_reg   <= '0;
    end else begin
      rd_valid_reg <= bus.rd_req;
      rd_hit_reg   <= hit_next;
      target_reg   <= tgt_next;
    end
  end

  assign bus.busy     = busy;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_hit   = rd_hit_reg;
  assign bus.target   = target_reg;

endmodule

// File: tb/tb_branch_target_table.sv
// Self-checking bench for branch_target_table: a table-level reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_branch_target_table;
  import btt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_target_table_if #(.IDX_W(4), .TGT_W(12), .BSEL_W(2)) bus ();

  branch_target_table #(.IDX_W(4), .TGT_W(12), .NUM_BASE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  tgt_t m_data [16];
  bit   m_valid[16];
  tgt_t m_base [4];
  int   m_sweep;            // cycles of clearing still to come
  bit   exp_valid, exp_hit, exp_busy;
  int   exp_tgt;
  bit   m_ev;
  int   m_ed, m_eb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < 4; i++)  m_base[i]  = '0;
      m_sweep = 0;
      exp_valid = 0; exp_hit = 0; exp_tgt = 0; exp_busy = 0;
    end else begin
      exp_valid = bus.rd_req;
      exp_hit = 0;
      exp_tgt = 0;
      if (bus.rd_req && m_sweep == 0) begin
        if (bus.wr_en && bus.wr_idx == bus.rd_idx) begin
          m_ev = 1; m_ed = int'(bus.wr_tgt);
        end else begin
          m_ev = m_valid[bus.rd_idx]; m_ed = int'(m_data[bus.rd_idx]);
        end
        if (bus.base_wr_en && bus.base_wr_sel == bus.rd_base_sel)
          m_eb = int'(bus.base_wr_val);
        else
          m_eb = int'(m_base[bus.rd_base_sel]);
        if (m_ev) begin
          exp_hit = 1;
          exp_tgt = (m_ed + m_eb) % 4096;
        end
      end
      if (bus.base_wr_en) m_base[bus.base_wr_sel] = bus.base_wr_val;
      if (m_sweep == 0 && bus.wr_en) begin
        m_data[bus.wr_idx]  = bus.wr_tgt;
        m_valid[bus.wr_idx] = 1'b1;
      end
      // A sweep makes the whole table invalid; reads miss until it ends.
      if (m_sweep == 0 && bus.clr_req) begin
        m_sweep = 16;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end else if (m_sweep > 0) begin
        m_sweep--;
      end
      exp_busy = (m_sweep > 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",     32'(bus.busy),     32'(exp_busy));
      chk("cyc_rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
      chk("cyc_rd_hit",   32'(bus.rd_hit),   32'(exp_hit));
      chk("cyc_target",   32'(bus.target),   32'(exp_tgt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr_req = 0; bus.wr_en = 0; bus.base_wr_en = 0; bus.rd_req = 0;
  endtask

  task automatic wr_entry(input int idx, input int val);
    bus.wr_en = 1; bus.wr_idx = 4'(idx); bus.wr_tgt = 12'(val);
    tick();
    bus.wr_en = 0;
  endtask

  task automatic wr_base(input int sel, input int val);
    bus.base_wr_en = 1; bus.base_wr_sel = 2'(sel); bus.base_wr_val = 12'(val);
    tick();
    bus.base_wr_en = 0;
  endtask

  task automatic rd(input int idx, input int sel);
    bus.rd_req = 1; bus.rd_idx = 4'(idx); bus.rd_base_sel = 2'(sel);
    tick();
    bus.rd_req = 0;
  endtask

  task automatic expect_rsp(input string name, input int hit, input int tgt);
    chk({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
    chk({name, "_hit"},   32'(bus.rd_hit),   32'(hit));
    chk({name, "_tgt"},   32'(bus.target),   32'(tgt));
  endtask

  int n;

  initial begin
    bus.wr_idx = '0; bus.wr_tgt = '0; bus.base_wr_sel = '0; bus.base_wr_val = '0;
    bus.rd_idx = '0; bus.rd_base_sel = '0;
    idle_inputs();
    tick(); tick();
    rst = 0;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_target", 32'(bus.target), 32'd0);
    chk_en = 1;

    // Reset mid-operation drops entry valid bits.
    wr_entry(3, 100);
    rst = 1; tick(); rst = 0;
    rd(3, 0);
    expect_rsp("rst_read", 0, 0);
    $display("txn reset_midop: rd idx3 hit=%0d tgt=%0d", bus.rd_hit, bus.target);

    // Base add.
    bus.base_wr_en = 1; bus.base_wr_sel = 2'd1; bus.base_wr_val = 12'd150;
    wr_entry(1, 4);
    bus.base_wr_en = 0;
    rd(1, 1); expect_rsp("base_add1", 1, 154);
    $display("txn base_add: idx1 sel1 tgt=%0d", bus.target);
    rd(1, 0); expect_rsp("base_add0", 1, 4);
    $display("txn base_add: idx1 sel0 tgt=%0d", bus.target);

    // Wrap-around.
    wr_base(2, 4000);
    wr_entry(5, 200);
    rd(5, 2); expect_rsp("wrap", 1, 104);
    $display("txn wrap: idx5 sel2 tgt=%0d", bus.target);

    // Both bypasses in one cycle.
    bus.wr_en = 1; bus.wr_idx = 4'd7; bus.wr_tgt = 12'd33;
    bus.base_wr_en = 1; bus.base_wr_sel = 2'd3; bus.base_wr_val = 12'd10;
    rd(7, 3);
    idle_inputs();
    expect_rsp("bypass", 1, 43);
    $display("txn bypass: idx7 sel3 tgt=%0d", bus.target);

    // Clear sweep.
    for (int i = 0; i < 16; i++) wr_entry(i, i * 3 + 1);
    bus.clr_req = 1;
    rd(4, 0);
    bus.clr_req = 0;
    expect_rsp("preclear_read", 1, 13);
    $display("txn clear_start: pre-clear idx4 tgt=%0d", bus.target);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      if (n == 3) begin
        bus.wr_en = 1; bus.wr_idx = 4'd2; bus.wr_tgt = 12'd77;
        bus.rd_req = 1; bus.rd_idx = 4'd2; bus.rd_base_sel = 2'd0;
      end else if (n == 4) begin
        expect_rsp("busy_read", 0, 0);
        idle_inputs();
      end
      tick();
    end
    chk("busy_cycles", 32'(n), 32'd16);
    $display("txn clear_sweep: busy cycles=%0d", n);
    for (int i = 0; i < 16; i++) begin
      rd(i, 1);
      expect_rsp("post_clear", 0, 0);
      $display("txn post_clear: idx%0d hit=%0d", i, bus.rd_hit);
    end
    wr_entry(0, 0);
    rd(0, 1); expect_rsp("base1_kept", 1, 150);
    rd(0, 2); expect_rsp("base2_kept", 1, 4000);
    rd(0, 3); expect_rsp("base3_kept", 1, 10);
    $display("txn base_kept: base3 via idx0 tgt=%0d", bus.target);

    // Reset during a sweep.
    bus.clr_req = 1; tick(); bus.clr_req = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("sweep_busy_before_rst", 32'(bus.busy), 32'd1);
    #2; rst = 1; #1;
    chk("async_busy_drop", 32'(bus.busy), 32'd0);
    @(posedge clk); #1; rst = 0;
    bus.wr_en = 1; bus.wr_idx = 4'd9; bus.wr_tgt = 12'd55;
    rd(9, 0);
    idle_inputs();
    expect_rsp("rst_sweep_bypass", 1, 55);
    rd(9, 0);
    expect_rsp("rst_sweep_read", 1, 55);
    $display("txn reset_sweep: idx9 hit=%0d tgt=%0d", bus.rd_hit, bus.target);

    tick(); tick();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_target_table.md
Name: branch_target_table

Overview:
- Programmable successor to the fixed 4-entry-pointer branch-target lookup in the fetch stage.
- Maps a short branch index to a full PC target. Entries and per-program base offsets are written at run time rather than hard-coded.
- Read has one-cycle registered latency and reports hit/miss per entry.
- A sequential clear engine invalidates the table between programs.
- Sits between the decode-stage branch index and the PC-select mux.

Parameters:
- IDX_W, 4, index width; DEPTH = 2**IDX_W entries.
- TGT_W, 12, target/PC width; also the width of each base register.
- NUM_BASE, 4, number of program-segment base registers (power of 2, >=2); BSEL_W = log2(NUM_BASE).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- clr_req  in  1  start clear sweep (sampled only in IDLE).
- busy  out  1  high while clear sweep is in progress.
- wr_en  in  1  entry write strobe.
- wr_idx  in  IDX_W  entry index to write.
- wr_tgt  in  TGT_W  entry value (segment-relative target).
- base_wr_en  in  1  base register write strobe.
- base_wr_sel  in  BSEL_W  base register to write.
- base_wr_val  in  TGT_W  base value.
- rd_req  in  1  lookup request.
- rd_idx  in  IDX_W  lookup index.
- rd_base_sel  in  BSEL_W  base register added to the entry.
- rd_valid  out  1  registered; response present this cycle.
- rd_hit  out  1  registered; entry was valid.
- Target  out  TGT_W  registered; absolute target.

Behaviour:
- Reset (async, any state): all entry valid bits 0; all base regs 0; state IDLE; busy=0, rd_valid=0, rd_hit=0, Target=0. Entry data is not reset.
- States:
  - IDLE: clr_req=1 -> CLEAR, sweep ptr=0, busy=1 the next cycle.
  - CLEAR: each cycle clears valid[ptr] and increments ptr. When ptr==DEPTH-1, clear that entry and go to IDLE. Sweep takes exactly DEPTH cycles with busy=1.
  - clr_req is ignored in CLEAR.
- Entry write (IDLE only, wr_en=1): data[wr_idx]=wr_tgt and valid[wr_idx]=1 at the edge. wr_en in CLEAR is dropped silently.
- Base write (any state, base_wr_en=1): base[base_wr_sel]=base_wr_val at the edge. Not affected by clear.
- Read, latency 1: rd_valid(t+1)=rd_req(t) in every state.
  - If rd_req and the entry is valid: rd_hit=1, Target=(data+base[rd_base_sel]) mod 2**TGT_W. Carry is discarded (wrap-around).
  - If the entry is invalid, or state is CLEAR: rd_hit=0, Target=0.
  - When rd_req=0: rd_valid=0, rd_hit=0, Target=0.
- Same-cycle bypass:
  - wr_en with wr_idx==rd_idx in IDLE: the read returns the new wr_tgt with hit=1.
  - base_wr_en with base_wr_sel==rd_base_sel: the read uses the new base_wr_val.
  - Both bypasses may apply together.
- Transition edges:
  - A read issued on the cycle clr_req is accepted in IDLE sees the pre-clear table.
  - The first cycle in IDLE after the sweep serves reads and writes normally.
- Reset asserted mid-sweep aborts the sweep: IDLE, all entries invalid.

Decomposition:
- Shared package btt_pkg holds:
  - state enum {IDLE, CLEAR}
  - default parameter constants IDX_W=4, TGT_W=12, NUM_BASE=4
  - helper typedefs tgt_t and idx_t.
- One sub-module, btt_clear_seq: the CLEAR FSM and sweep pointer, with outputs busy, clr_we, clr_idx.
- Entry storage, base registers, bypass and the output register stay in the top level.

Test Plan:
- Reset mid-operation:
  - Write idx 3 = 100, assert Reset for 1 cycle, read idx 3 with base_sel 0.
  - Expect rd_valid=1, rd_hit=0, Target=0.
- Base add:
  - Write base[1]=150 and entry idx 1=4, then read idx 1, base_sel 1.
  - Next cycle expect rd_valid=1, rd_hit=1, Target=154.
  - Same read with base_sel 0 gives Target=4.
- Wrap-around:
  - base[2]=4000, entry idx 5=200, read idx 5, base_sel 2.
  - Expect Target=104 ((4200) mod 4096), rd_hit=1.
- Bypass:
  - In one cycle: wr_en idx 7=33, base_wr_en sel 3=10, rd_req idx 7 with base_sel 3.
  - Next cycle expect rd_hit=1, Target=43.
- Clear sweep:
  - Fill all 16 entries, pulse clr_req.
  - Expect busy=1 for exactly 16 cycles.
  - A write to idx 2 during busy is dropped.
  - Reads during busy give hit=0.
  - After busy falls, every index reads hit=0 and base registers are unchanged.
- Reset during CLEAR:
  - Assert Reset at sweep cycle 5.
  - Expect busy=0 immediately (async), state IDLE.
  - A write/read of idx 9 on the cycle after release gives a hit next cycle.
